// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - emulates one key of a 4x4 scanned matrix keypad, with contact bounce
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_valid  in   request to press key_code
//   key_code   in   [3:0] hex key to press
//   key_ready  out  request accepted when high (IDLE only)
//   columnas   in   [3:0] column drive from the scanner, bit 3 = column 0
//   filas      out  [3:0] registered row return
//   busy       out  key sequence in progress
//   done       out  one-cycle pulse on the GAP -> IDLE transition
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 20000,
    parameter int unsigned BOUNCE_CYCLES = 200,
    parameter int unsigned TOGGLE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES    = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        GAP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] cnt;
    logic [3:0]  key_q;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic        toggled;
    logic        contact;

    function automatic logic [31:0] phase_len(input state_t s);
        case (s)
            PRESS_BOUNCE:   return BOUNCE_CYCLES;
            HOLD:           return HOLD_CYCLES;
            RELEASE_BOUNCE: return BOUNCE_CYCLES;
            GAP:            return GAP_CYCLES;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            IDLE:           return PRESS_BOUNCE;
            PRESS_BOUNCE:   return HOLD;
            HOLD:           return RELEASE_BOUNCE;
            RELEASE_BOUNCE: return GAP;
            default:        return IDLE;
        endcase
    endfunction

    // Zero-length phases are stepped over so they occupy no cycles at all.
    function automatic state_t skip_empty(input state_t s);
        state_t r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (r != IDLE && phase_len(r) == 32'd0) begin
                r = succ(r);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 32'd0;
            key_q <= 4'h0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= 32'd0;
            end else if (state != IDLE) begin
                cnt <= cnt + 32'd1;
            end
            if (state == IDLE && key_valid) begin
                key_q <= key_code;
            end
        end
    end

    always_comb begin
        next_state = state;
        key_ready  = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    next_state = skip_empty(PRESS_BOUNCE);
                end
            end
            default: begin
                if (cnt == phase_len(state) - 32'd1) begin
                    next_state = skip_empty(succ(state));
                end
            end
        endcase
    end

    assign done = (state != IDLE) && (next_state == IDLE);
    assign busy = ~key_ready;

    // Bounce slot parity: even slots keep the phase's starting level.
    assign toggled = ((cnt / TOGGLE_CYCLES) & 32'd1) != 32'd0;

    always_comb begin
        contact = 1'b0;
        case (state)
            PRESS_BOUNCE:   contact = ~toggled;
            HOLD:           contact = 1'b1;
            RELEASE_BOUNCE: contact = toggled;
            default:        contact = 1'b0;
        endcase
    end

    always_comb begin
        {key_col, key_row} = 8'h00;
        case (key_q)
            4'hD: {key_col, key_row} = 8'h11;
            4'hC: {key_col, key_row} = 8'h12;
            4'hB: {key_col, key_row} = 8'h14;
            4'hA: {key_col, key_row} = 8'h18;
            4'hF: {key_col, key_row} = 8'h21;
            4'h9: {key_col, key_row} = 8'h22;
            4'h6: {key_col, key_row} = 8'h24;
            4'h3: {key_col, key_row} = 8'h28;
            4'h0: {key_col, key_row} = 8'h41;
            4'h8: {key_col, key_row} = 8'h42;
            4'h5: {key_col, key_row} = 8'h44;
            4'h2: {key_col, key_row} = 8'h48;
            4'hE: {key_col, key_row} = 8'h81;
            4'h7: {key_col, key_row} = 8'h82;
            4'h4: {key_col, key_row} = 8'h84;
            4'h1: {key_col, key_row} = 8'h88;
            default: {key_col, key_row} = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filas <= 4'h0;
        end else if (contact && ((columnas & key_col) != 4'h0)) begin
            filas <= key_row;
        end else begin
            filas <= 4'h0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;

    localparam int PB = 8;
    localparam int HC = 40;
    localparam int RB = 8;
    localparam int GC = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic       busy;
    logic       done;

    logic       valid0;
    logic [3:0] code0;
    logic       ready0;
    logic [3:0] cols0;
    logic [3:0] filas0;
    logic       busy0;
    logic       done0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(HC), .BOUNCE_CYCLES(PB), .TOGGLE_CYCLES(2), .GAP_CYCLES(GC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .columnas(columnas), .filas(filas),
        .busy(busy), .done(done)
    );

    keypad_emulator #(
        .HOLD_CYCLES(HC), .BOUNCE_CYCLES(0), .TOGGLE_CYCLES(2), .GAP_CYCLES(GC)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .key_valid(valid0), .key_code(code0),
        .key_ready(ready0), .columnas(cols0), .filas(filas0),
        .busy(busy0), .done(done0)
    );

    typedef struct {
        logic [3:0] code;
        logic [3:0] cols;
        logic [3:0] exp_filas;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (key_ready) break;
            step();
        end
        check("wait_idle", {31'd0, key_ready}, 32'd1);
    endtask

    // Contact level during the k-th cycle after the accept edge (main instance).
    function automatic bit exp_contact(input int k);
        if (k < 0) return 1'b0;
        if (k < PB) return ((k / 2) % 2) == 0;
        if (k < PB + HC) return 1'b1;
        if (k < PB + HC + RB) return (((k - PB - HC) / 2) % 2) == 1;
        return 1'b0;
    endfunction

    initial begin
        logic [3:0] pat[4];
        logic [3:0] prev;
        logic [3:0] expf;
        int         hi_cnt, first_hi, last_hi, done_at, done_cnt, ready_hi, filas_hi;

        vecs[0]  = '{4'hD, 4'h1, 4'h1};  vecs[1]  = '{4'hC, 4'h1, 4'h2};
        vecs[2]  = '{4'hB, 4'h1, 4'h4};  vecs[3]  = '{4'hA, 4'h1, 4'h8};
        vecs[4]  = '{4'hF, 4'h2, 4'h1};  vecs[5]  = '{4'h9, 4'h2, 4'h2};
        vecs[6]  = '{4'h6, 4'h2, 4'h4};  vecs[7]  = '{4'h3, 4'h2, 4'h8};
        vecs[8]  = '{4'h0, 4'h4, 4'h1};  vecs[9]  = '{4'h8, 4'h4, 4'h2};
        vecs[10] = '{4'h5, 4'h4, 4'h4};  vecs[11] = '{4'h2, 4'h4, 4'h8};
        vecs[12] = '{4'hE, 4'h8, 4'h1};  vecs[13] = '{4'h7, 4'h8, 4'h2};
        vecs[14] = '{4'h4, 4'h8, 4'h4};  vecs[15] = '{4'h1, 4'h8, 4'h8};
        vecs[16] = '{4'hE, 4'hF, 4'h1};  vecs[17] = '{4'hE, 4'h0, 4'h0};
        vecs[18] = '{4'h5, 4'h8, 4'h0};  vecs[19] = '{4'h1, 4'h9, 4'h8};
        pat[0] = 4'b1000; pat[1] = 4'b0100; pat[2] = 4'b0010; pat[3] = 4'b0001;

        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; columnas = 4'h0;
        valid0 = 1'b0; code0 = 4'h0; cols0 = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, key_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_filas", {28'd0, filas}, 32'd0);

        // Key 5, column 0100 held, accepted on the first edge after reset release
        rst_n = 1'b1; key_valid = 1'b1; key_code = 4'h5; columnas = 4'b0100;
        step();
        key_valid = 1'b0;
        check("k5_busy_after_accept", {31'd0, busy}, 32'd1);
        for (int m = 1; m <= 70; m++) begin
            step();
            expf = exp_contact(m - 1) ? 4'b0100 : 4'b0000;
            check($sformatf("k5_filas_m%0d", m), {28'd0, filas}, {28'd0, expf});
            check($sformatf("k5_done_m%0d", m), {31'd0, done}, {31'd0, m == PB + HC + RB + GC - 1});
            check($sformatf("k5_busy_m%0d", m), {31'd0, busy}, {31'd0, m < PB + HC + RB + GC});
        end

        // Key 1 with the scanner rotating columns every 5 cycles
        wait_idle();
        key_valid = 1'b1; key_code = 4'h1; columnas = pat[0];
        prev = columnas;
        step();
        key_valid = 1'b0;
        for (int m = 1; m <= 70; m++) begin
            step();
            expf = (exp_contact(m - 1) && prev == 4'b1000) ? 4'b1000 : 4'b0000;
            check($sformatf("k1_scan_m%0d", m), {28'd0, filas}, {28'd0, expf});
            columnas = pat[(m / 5) % 4];
            prev = columnas;
        end

        // No-bounce instance: key D, solid 40-cycle closure, done on edge 50
        valid0 = 1'b1; code0 = 4'hD; cols0 = 4'b0001;
        step();
        valid0 = 1'b0;
        hi_cnt = 0; first_hi = -1; last_hi = -1; done_at = -1; done_cnt = 0;
        for (int m = 1; m <= 60; m++) begin
            step();
            if (filas0 == 4'b0001) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = m;
                last_hi = m;
            end
            if (done0) begin
                done_cnt++;
                done_at = m;
            end
        end
        check("nb_hi_cycles", hi_cnt, 40);
        check("nb_first_hi", first_hi, 1);
        check("nb_last_hi", last_hi, 40);
        check("nb_done_edge", done_at + 1, 50);
        check("nb_done_count", done_cnt, 1);
        check("nb_idle_after", {31'd0, ready0}, 32'd1);

        // Table: key/column combinations sampled mid-HOLD
        for (int v = 0; v < 20; v++) begin
            wait_idle();
            key_valid = 1'b1; key_code = vecs[v].code; columnas = vecs[v].cols;
            step();
            key_valid = 1'b0;
            for (int m = 0; m < 20; m++) step();
            check($sformatf("tbl%0d_key%0h_col%0h", v, vecs[v].code, vecs[v].cols),
                  {28'd0, filas}, {28'd0, vecs[v].exp_filas});
        end

        // key_valid held: A accepted, 3 refused until A completes
        wait_idle();
        columnas = 4'b0010;
        key_valid = 1'b1; key_code = 4'hA;
        step();
        key_code = 4'h3;
        done_at = -1; ready_hi = 0; filas_hi = 0;
        for (int m = 1; m <= 100; m++) begin
            step();
            if (done) begin
                done_at = m;
                break;
            end
            if (key_ready) ready_hi++;
            if (filas != 4'h0) filas_hi++;
        end
        check("hold_a_done_edge", done_at + 1, PB + HC + RB + GC);
        check("hold_a_ready_low", ready_hi, 0);
        check("hold_a_filas_zero", filas_hi, 0);
        step();
        check("hold_idle_after_done", {31'd0, key_ready}, 32'd1);
        step();
        check("hold_3_accepted", {31'd0, busy}, 32'd1);
        key_valid = 1'b0;
        for (int m = 1; m <= 20; m++) step();
        check("hold_3_row", {28'd0, filas}, 32'h8);

        // Reset during HOLD of key 9
        wait_idle();
        columnas = 4'b0010;
        key_valid = 1'b1; key_code = 4'h9;
        step();
        key_valid = 1'b0;
        for (int m = 1; m <= 20; m++) step();
        check("rst_pre_filas", {28'd0, filas}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_filas", {28'd0, filas}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_ready", {31'd0, key_ready}, 32'd1);
        check("rst_async_done", {31'd0, done}, 32'd0);
        done_cnt = 0;
        for (int m = 0; m < 4; m++) begin
            step();
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        rst_n = 1'b1; key_valid = 1'b1; key_code = 4'h9;
        step();
        key_valid = 1'b0;
        check("rst_first_accept", {31'd0, busy}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
